// File: rtl/spi_coeff_ctrl_if.sv
// SPI-slave and coefficient-RAM signal bundle for spi_coeff_ctrl.
// master = controller view, slave = SPI receiver / RAM side.
interface spi_coeff_ctrl_if #(
  parameter int P_COEFF_NBITS = 24,
  parameter int P_ADDR_NBITS  = 7
);
  logic                       i_frame_active;
  logic                       i_rx_cmd_rdy;
  logic                       i_rx_data_rdy;
  logic [8+P_COEFF_NBITS-1:0] i_rx_buf;
  logic                       o_tx_load;
  logic [P_COEFF_NBITS-1:0]   o_tx_data;
  logic                       o_mem_we;
  logic                       o_mem_re;
  logic [P_ADDR_NBITS-1:0]    o_mem_addr;
  logic [P_COEFF_NBITS-1:0]   o_mem_wdata;
  logic [P_COEFF_NBITS-1:0]   i_mem_rdata;

  modport master (
    input  i_frame_active, i_rx_cmd_rdy, i_rx_data_rdy, i_rx_buf, i_mem_rdata,
    output o_tx_load, o_tx_data, o_mem_we, o_mem_re, o_mem_addr, o_mem_wdata
  );

  modport slave (
    output i_frame_active, i_rx_cmd_rdy, i_rx_data_rdy, i_rx_buf, i_mem_rdata,
    input  o_tx_load, o_tx_data, o_mem_we, o_mem_re, o_mem_addr, o_mem_wdata
  );
endinterface

// File: rtl/spi_coeff_ctrl.sv
// SPI frame sequencer for the crossover coefficient RAM: writes, bank commit, error count.
// Readback path (RAM read -> tx buffer) compiled in only when SPI_COEFF_READBACK_EN is defined.
module spi_coeff_ctrl #(
  parameter int P_COEFF_NBITS = 24,
  parameter int P_ADDR_NBITS  = 7,
  parameter int P_NCOEFF      = 100
) (
  input  logic             i_clk,
  input  logic             i_rst,
  spi_coeff_ctrl_if.master bus,
  output logic             o_bank_swap,
  output logic             o_busy,
  output logic [7:0]       o_err_cnt
);
  localparam int CMD_MSB = 8 + P_COEFF_NBITS - 1;
  localparam logic [P_ADDR_NBITS-1:0] NCOEFF = P_ADDR_NBITS'(P_NCOEFF);
  localparam logic [P_ADDR_NBITS-1:0] COMMIT = '1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CMD,
`ifdef SPI_COEFF_READBACK_EN
    S_RD_ISSUE,
    S_RD_WAIT,
    S_RD_LOAD,
`endif
    S_DATA,
    S_WR,
    S_DONE
  } state_e;

  state_e                   state_q, state_d;
  logic                     frame_q, cmd_prev_q, data_prev_q, cmd_rise_q, data_rise_q;
  logic                     rd_q, rd_d;
  logic [P_ADDR_NBITS-1:0]  addr_q, addr_d;
  logic [P_COEFF_NBITS-1:0] wdata_q, wdata_d, tx_data_q, tx_data_d;
  logic                     tx_load_q, tx_load_d, we_q, we_d, re_q, re_d, swap_q, swap_d;
  logic [7:0]               err_q, err_d;
  logic                     err_inc, frame_rise, rd_ok;
  logic [7:0]               cmd_byte;
  logic [P_ADDR_NBITS-1:0]  cmd_addr;

  assign frame_rise = bus.i_frame_active & ~frame_q;
  assign cmd_byte   = bus.i_rx_buf[CMD_MSB -: 8];
  assign cmd_addr   = cmd_byte[P_ADDR_NBITS-1:0];

`ifdef SPI_COEFF_READBACK_EN
  assign rd_ok = (cmd_addr < NCOEFF);
`else
  assign rd_ok = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    rd_d      = rd_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    tx_data_d = tx_data_q;
    tx_load_d = 1'b0;
    we_d      = 1'b0;
    re_d      = 1'b0;
    swap_d    = 1'b0;
    err_inc   = 1'b0;
    // A new frame always restarts decoding; only a clean DONE->start is not an error
    if (frame_rise && state_q != S_IDLE) begin
      state_d = S_CMD;
      err_inc = (state_q != S_DONE);
    end else begin
      case (state_q)
        S_IDLE: if (frame_rise) state_d = S_CMD;
        S_CMD: begin
          if (!bus.i_frame_active) begin
            state_d = S_IDLE;
            err_inc = 1'b1;
          end else if (cmd_rise_q) begin
            rd_d    = cmd_byte[7];
            addr_d  = cmd_addr;
            state_d = S_DATA;
            if (!cmd_byte[7]) begin
              state_d = S_DATA;
            end else if (rd_ok) begin
`ifdef SPI_COEFF_READBACK_EN
              state_d = S_RD_ISSUE;
              re_d    = 1'b1;
`endif
            end else begin
              tx_data_d = '0;
              tx_load_d = 1'b1;
              err_inc   = 1'b1;
            end
          end
        end
`ifdef SPI_COEFF_READBACK_EN
        S_RD_ISSUE: state_d = S_RD_WAIT;
        S_RD_WAIT: begin
          state_d   = S_RD_LOAD;
          tx_data_d = bus.i_mem_rdata;
          tx_load_d = 1'b1;
        end
        S_RD_LOAD: state_d = S_DATA;
`endif
        S_DATA: begin
          if (!bus.i_frame_active) begin
            state_d = S_IDLE;
            err_inc = 1'b1;
          end else if (data_rise_q) begin
            if (rd_q) begin
              state_d = S_DONE;
            end else begin
              state_d = S_WR;
              wdata_d = bus.i_rx_buf[P_COEFF_NBITS-1:0];
              if (addr_q < NCOEFF)       we_d    = 1'b1;
              else if (addr_q == COMMIT) swap_d  = 1'b1;
              else                       err_inc = 1'b1;
            end
          end
        end
        S_WR:   state_d = S_DONE;
        S_DONE: if (!bus.i_frame_active) state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
    err_d = (err_inc && err_q != 8'hFF) ? err_q + 8'd1 : err_q;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q     <= S_IDLE;
      frame_q     <= 1'b0;
      cmd_prev_q  <= 1'b0;
      data_prev_q <= 1'b0;
      cmd_rise_q  <= 1'b0;
      data_rise_q <= 1'b0;
      rd_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      tx_data_q   <= '0;
      tx_load_q   <= 1'b0;
      we_q        <= 1'b0;
      re_q        <= 1'b0;
      swap_q      <= 1'b0;
      err_q       <= 8'd0;
    end else begin
      state_q     <= state_d;
      frame_q     <= bus.i_frame_active;
      cmd_prev_q  <= bus.i_rx_cmd_rdy;
      data_prev_q <= bus.i_rx_data_rdy;
      cmd_rise_q  <= bus.i_rx_cmd_rdy & ~cmd_prev_q;
      data_rise_q <= bus.i_rx_data_rdy & ~data_prev_q;
      rd_q        <= rd_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      tx_data_q   <= tx_data_d;
      tx_load_q   <= tx_load_d;
      we_q        <= we_d;
      re_q        <= re_d;
      swap_q      <= swap_d;
      err_q       <= err_d;
    end
  end

  assign bus.o_tx_load   = tx_load_q;
  assign bus.o_tx_data   = tx_data_q;
  assign bus.o_mem_we    = we_q;
  assign bus.o_mem_re    = re_q;
  assign bus.o_mem_addr  = addr_q;
  assign bus.o_mem_wdata = wdata_q;
  assign o_bank_swap     = swap_q;
  assign o_busy          = (state_q != S_IDLE);
  assign o_err_cnt       = err_q;
endmodule

// File: tb/tb_spi_coeff_ctrl.sv
// Bench for spi_coeff_ctrl: directed vector table, randomized frames against a frame-level
// model with its own coefficient array, error saturation and mid-frame reset.
module tb_spi_coeff_ctrl;
`ifdef SPI_COEFF_READBACK_EN
  localparam bit RB = 1'b1;
`else
  localparam bit RB = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       swap, busy;
  logic [7:0] err_cnt;

  spi_coeff_ctrl_if bus ();

  spi_coeff_ctrl dut (
    .i_clk(clk), .i_rst(rst), .bus(bus),
    .o_bank_swap(swap), .o_busy(busy), .o_err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // coefficient RAM standing behind the controller
  logic [23:0] ram [128];
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 128; i++) ram[i] <= '0;
      bus.i_mem_rdata <= '0;
    end else begin
      if (bus.o_mem_we) ram[bus.o_mem_addr] <= bus.o_mem_wdata;
      if (bus.o_mem_re) bus.i_mem_rdata <= ram[bus.o_mem_addr];
    end
  end

  int t_cmd, t_data;
  int n_we = 0, n_re = 0, n_swap = 0, n_load = 0, n_both = 0;
  int we_dly, ld_dly;
  logic [6:0]  we_addr;
  logic [23:0] we_data, tx_seen;
  always @(negedge clk) begin
    if (bus.o_mem_we) begin
      n_we    <= n_we + 1;
      we_addr <= bus.o_mem_addr;
      we_data <= bus.o_mem_wdata;
      we_dly  <= cyc - t_data;
    end
    if (bus.o_mem_re) n_re <= n_re + 1;
    if (bus.o_mem_we && bus.o_mem_re) n_both <= n_both + 1;
    if (swap) n_swap <= n_swap + 1;
    if (bus.o_tx_load) begin
      n_load  <= n_load + 1;
      tx_seen <= bus.o_tx_data;
      ld_dly  <= cyc - t_cmd;
    end
  end

  int checks = 0, errors = 0;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic run_frame(input logic [7:0] cmd, input logic [23:0] data, input bit abort);
    @(negedge clk);
    bus.i_frame_active = 1'b1;
    bus.i_rx_buf       = {cmd, 24'h0};
    repeat (3) @(negedge clk);
    bus.i_rx_cmd_rdy = 1'b1;
    t_cmd            = cyc;
    repeat (12) @(negedge clk);
    if (!abort) begin
      bus.i_rx_buf      = {cmd, data};
      bus.i_rx_data_rdy = 1'b1;
      t_data            = cyc;
      repeat (6) @(negedge clk);
    end
    bus.i_frame_active = 1'b0;
    bus.i_rx_cmd_rdy   = 1'b0;
    bus.i_rx_data_rdy  = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  typedef struct {
    logic [7:0]  cmd;
    logic [23:0] data;
    bit          abort;
    int          exp_we;
    int          exp_swap;
    int          exp_load;
    logic [23:0] exp_tx;
    int          exp_dly;
    int          exp_err;
  } vec_t;

  vec_t        vecs[8];
  logic [23:0] mram[128];
  int          nr;
  int          s_we, s_swap, s_load;
  int          m_err, m_we, m_swap, m_load;
  logic [23:0] m_tx;
  int          m_dly;

  task automatic check_frame(input string tag, input logic [7:0] cmd, input logic [23:0] data,
                             input int e_we, input int e_swap, input int e_load,
                             input logic [23:0] e_tx, input int e_dly, input int e_err);
    chk({tag, " we_cnt"}, n_we - s_we, e_we);
    chk({tag, " swap_cnt"}, n_swap - s_swap, e_swap);
    chk({tag, " load_cnt"}, n_load - s_load, e_load);
    if (e_we == 1) begin
      chk({tag, " we_addr"}, {25'd0, we_addr}, {25'd0, cmd[6:0]});
      chk({tag, " we_data"}, {8'd0, we_data}, {8'd0, data});
      chk({tag, " we_dly"}, we_dly, 2);
    end
    if (e_load == 1) begin
      chk({tag, " tx_data"}, {8'd0, tx_seen}, {8'd0, e_tx});
      chk({tag, " load_dly"}, ld_dly, e_dly);
    end
    chk({tag, " err_cnt"}, {24'd0, err_cnt}, e_err);
    chk({tag, " busy_idle"}, {31'd0, busy}, 0);
  endtask

  initial begin
    nr = RB ? 0 : 1;
    vecs[0] = '{8'h05, 24'h123456, 0, 1, 0, 0, 24'h0, 0, 0};
    vecs[1] = '{8'h05, 24'hABCDEF, 0, 1, 0, 0, 24'h0, 0, 0};
    vecs[2] = '{8'h85, 24'h0, 0, 0, 0, 1, RB ? 24'hABCDEF : 24'h0, RB ? 4 : 2, nr};
    vecs[3] = '{8'h7F, 24'h000001, 0, 0, 1, 0, 24'h0, 0, nr};
    vecs[4] = '{8'h64, 24'h111111, 0, 0, 0, 0, 24'h0, 0, nr + 1};
    vecs[5] = '{8'hE4, 24'h0, 0, 0, 0, 1, 24'h0, 2, nr + 2};
    vecs[6] = '{8'h05, 24'h0, 1, 0, 0, 0, 24'h0, 0, nr + 3};
    vecs[7] = '{8'h85, 24'h0, 1, 0, 0, 1, RB ? 24'hABCDEF : 24'h0, RB ? 4 : 2, nr + 4 + nr};
    for (int i = 0; i < 128; i++) mram[i] = '0;

    rst = 1'b1;
    bus.i_frame_active = 1'b0;
    bus.i_rx_cmd_rdy   = 1'b0;
    bus.i_rx_data_rdy  = 1'b0;
    bus.i_rx_buf       = '0;
    t_cmd = 0;
    t_data = 0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst tx_load", {31'd0, bus.o_tx_load}, 0);
    chk("rst tx_data", {8'd0, bus.o_tx_data}, 0);
    chk("rst mem_we", {31'd0, bus.o_mem_we}, 0);
    chk("rst mem_re", {31'd0, bus.o_mem_re}, 0);
    chk("rst mem_addr", {25'd0, bus.o_mem_addr}, 0);
    chk("rst mem_wdata", {8'd0, bus.o_mem_wdata}, 0);
    chk("rst swap", {31'd0, swap}, 0);
    chk("rst busy", {31'd0, busy}, 0);
    chk("rst err_cnt", {24'd0, err_cnt}, 0);

    for (int i = 0; i < 8; i++) begin
      s_we = n_we; s_swap = n_swap; s_load = n_load;
      run_frame(vecs[i].cmd, vecs[i].data, vecs[i].abort);
      check_frame($sformatf("vec%0d", i), vecs[i].cmd, vecs[i].data, vecs[i].exp_we,
                  vecs[i].exp_swap, vecs[i].exp_load, vecs[i].exp_tx, vecs[i].exp_dly,
                  vecs[i].exp_err);
      if (vecs[i].exp_we == 1) mram[vecs[i].cmd[6:0]] = vecs[i].data;
    end

    m_err = 2 * nr + 4;
    for (int f = 0; f < 40; f++) begin
      int          sel, a;
      bit          rd, ab;
      logic [23:0] d;
      sel = $urandom_range(0, 9);
      a   = (sel < 6) ? $urandom_range(0, 99) : (sel < 8) ? $urandom_range(100, 126) : 127;
      rd  = $urandom_range(0, 1) == 1;
      ab  = $urandom_range(0, 5) == 0;
      d   = 24'($urandom);
      m_we = 0; m_swap = 0; m_load = 0; m_tx = '0; m_dly = 0;
      if (rd) begin
        m_load = 1;
        if (RB && a < 100) begin
          m_tx = mram[a]; m_dly = 4;
        end else begin
          m_dly = 2; m_err++;
        end
      end else if (!ab) begin
        if (a < 100) begin
          m_we = 1; mram[a] = d;
        end else if (a == 127) m_swap = 1;
        else m_err++;
      end
      if (ab) m_err++;
      if (m_err > 255) m_err = 255;
      s_we = n_we; s_swap = n_swap; s_load = n_load;
      run_frame({rd, 7'(a)}, d, ab);
      check_frame($sformatf("rnd%0d", f), {rd, 7'(a)}, d, m_we, m_swap, m_load, m_tx, m_dly,
                  m_err);
    end
    for (int i = 0; i < 100; i++) chk($sformatf("ram[%0d]", i), {8'd0, ram[i]}, {8'd0, mram[i]});

    for (int k = 0; k < 300; k++) run_frame(8'h05, 24'h0, 1'b1);
    chk("err_saturate", {24'd0, err_cnt}, 255);

    @(negedge clk);
    bus.i_frame_active = 1'b1;
    bus.i_rx_buf       = {8'h06, 24'h0};
    repeat (3) @(negedge clk);
    bus.i_rx_cmd_rdy = 1'b1;
    repeat (8) @(negedge clk);
    chk("busy_in_data", {31'd0, busy}, 1);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst busy", {31'd0, busy}, 0);
    chk("midrst err_cnt", {24'd0, err_cnt}, 0);
    chk("midrst mem_addr", {25'd0, bus.o_mem_addr}, 0);
    chk("midrst strobes", {28'd0, bus.o_mem_we, bus.o_mem_re, bus.o_tx_load, swap}, 0);
    chk("midrst tx_data", {8'd0, bus.o_tx_data}, 0);
    rst = 1'b0;
    bus.i_frame_active = 1'b0;
    bus.i_rx_cmd_rdy   = 1'b0;
    repeat (3) @(negedge clk);
    s_we = n_we; s_swap = n_swap; s_load = n_load;
    run_frame(8'h06, 24'h0BEEF0, 1'b0);
    check_frame("post_rst", 8'h06, 24'h0BEEF0, 1, 0, 0, 24'h0, 0, 0);
    chk("ram_after_rst", {8'd0, ram[6]}, 32'h000BEEF0);
    chk("re_count", n_re, 0);
    chk("we_re_overlap", n_both, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
